// File: rtl/booth_product_accumulator.sv
// Accumulates signed Booth-multiplier products into saturating group sums,
// presenting each group result on a held valid/ready output handshake.
module booth_product_accumulator #(
  parameter int NUM_BITS = 4,
  parameter int ACC_LEN  = 4,
  parameter int ACC_BITS = 10
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [2*NUM_BITS-1:0]          in_prod,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_BITS-1:0]            out_sum,
  output logic                           out_sat,
  output logic [$clog2(ACC_LEN+1)-1:0]   out_count
);

  localparam int PROD_W = 2 * NUM_BITS;
  localparam int CNT_W  = $clog2(ACC_LEN + 1);
  localparam logic [CNT_W-1:0]    LEN_C = CNT_W'(ACC_LEN);
  localparam logic [ACC_BITS-1:0] MAX_C = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic [ACC_BITS-1:0] MIN_C = {1'b1, {(ACC_BITS-1){1'b0}}};

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ACC_BITS-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sat_q, sat_d;
  logic [ACC_BITS-1:0] sum_q, sum_d;
  logic                osat_q, osat_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [ACC_BITS:0]   nxt_wide;
  logic [ACC_BITS-1:0] nxt_clamped;
  logic                nxt_ovf;
  logic [CNT_W-1:0]    cnt_inc;
  logic                accept;
  logic                close;

  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_OUT);
  assign out_sum   = sum_q;
  assign out_sat   = osat_q;
  assign out_count = count_q;

  assign accept  = in_valid & in_ready;
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign close   = accept & ((cnt_inc == LEN_C) | in_last);

  // One guard bit is enough: the two top bits disagree exactly when the
  // true sum leaves the ACC_BITS signed range.
  always_comb begin
    nxt_wide = {acc_q[ACC_BITS-1], acc_q}
             + {{(ACC_BITS+1-PROD_W){in_prod[PROD_W-1]}}, in_prod};
    nxt_ovf  = nxt_wide[ACC_BITS] ^ nxt_wide[ACC_BITS-1];
    if (!nxt_ovf) begin
      nxt_clamped = nxt_wide[ACC_BITS-1:0];
    end else if (nxt_wide[ACC_BITS]) begin
      nxt_clamped = MIN_C;
    end else begin
      nxt_clamped = MAX_C;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    sum_d   = sum_q;
    osat_d  = osat_q;
    count_d = count_q;
    case (state_q)
      S_ACC: begin
        if (accept) begin
          acc_d = nxt_clamped;
          cnt_d = cnt_inc;
          sat_d = sat_q | nxt_ovf;
          if (close) begin
            state_d = S_OUT;
            sum_d   = nxt_clamped;
            osat_d  = sat_q | nxt_ovf;
            count_d = cnt_inc;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_ACC;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      sum_q   <= '0;
      osat_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      sum_q   <= sum_d;
      osat_q  <= osat_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Bench for booth_product_accumulator: a 10-bit and an 8-bit accumulator
// share one stimulus stream and are compared to an integer reference model.
module tb_booth_product_accumulator;

  localparam int ACC_LEN = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_prod = '0;

  logic       in_ready_a, out_valid_a, sat_a;
  logic [9:0] sum_a;
  logic [2:0] cnt_a;
  logic       in_ready_b, out_valid_b, sat_b;
  logic [7:0] sum_b;
  logic [2:0] cnt_b;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  booth_product_accumulator #(.NUM_BITS(4), .ACC_LEN(ACC_LEN), .ACC_BITS(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_sum(sum_a), .out_sat(sat_a), .out_count(cnt_a)
  );

  booth_product_accumulator #(.NUM_BITS(4), .ACC_LEN(ACC_LEN), .ACC_BITS(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_sum(sum_b), .out_sat(sat_b), .out_count(cnt_b)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Reference model: group sums as plain integers with clamping per width.
  int m_acc [2];
  bit m_sat [2];
  int m_osum [2];
  bit m_osat [2];
  int m_cnt, m_ocnt;
  bit m_out;
  bit m_idle0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < 2; w++) begin
        m_acc[w] = 0; m_sat[w] = 0; m_osum[w] = 0; m_osat[w] = 0;
      end
      m_cnt = 0; m_ocnt = 0; m_out = 0; m_idle0 = 1;
    end else if (!m_out) begin
      if (in_valid) begin
        m_cnt++;
        for (int w = 0; w < 2; w++) begin
          int bits, hi, lo, s;
          bits = (w == 0) ? 10 : 8;
          hi = (1 << (bits - 1)) - 1;
          lo = -(1 << (bits - 1));
          s = m_acc[w] + int'($signed(in_prod));
          if (s > hi) begin s = hi; m_sat[w] = 1; end
          else if (s < lo) begin s = lo; m_sat[w] = 1; end
          m_acc[w] = s;
        end
        if (m_cnt == ACC_LEN || in_last) begin
          m_out = 1; m_idle0 = 0; m_ocnt = m_cnt;
          for (int w = 0; w < 2; w++) begin
            m_osum[w] = m_acc[w]; m_osat[w] = m_sat[w];
          end
        end
      end
    end else if (out_ready) begin
      m_out = 0; m_cnt = 0;
      for (int w = 0; w < 2; w++) begin m_acc[w] = 0; m_sat[w] = 0; end
    end
    #1;
    chk("mon in_ready10", int'(in_ready_a), int'(!m_out));
    chk("mon in_ready8", int'(in_ready_b), int'(!m_out));
    chk("mon out_valid10", int'(out_valid_a), int'(m_out));
    chk("mon out_valid8", int'(out_valid_b), int'(m_out));
    if (m_out || m_idle0) begin
      chk("mon out_sum10", int'($signed(sum_a)), m_osum[0]);
      chk("mon out_sum8", int'($signed(sum_b)), m_osum[1]);
      chk("mon out_sat10", int'(sat_a), int'(m_osat[0]));
      chk("mon out_sat8", int'(sat_b), int'(m_osat[1]));
      chk("mon out_count", int'(cnt_a), m_ocnt);
      chk("mon out_count8", int'(cnt_b), m_ocnt);
    end
  end

  typedef struct {
    int n; bit lst;
    int p0; int p1; int p2; int p3;
    int s10; bit t10; int s8; bit t8; int c;
  } vec_t;

  vec_t vecs [10];

  task automatic beat(input int p, input bit l);
    @(negedge clk);
    in_valid = 1'b1; in_prod = 8'(p); in_last = l;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic take();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic chk_grp(input string nm, input int s10, input bit t10,
                         input int s8, input bit t8, input int c);
    chk({nm, " out_valid"}, int'(out_valid_a), 1);
    chk({nm, " in_ready"}, int'(in_ready_a), 0);
    chk({nm, " sum10"}, int'($signed(sum_a)), s10);
    chk({nm, " sat10"}, int'(sat_a), int'(t10));
    chk({nm, " sum8"}, int'($signed(sum_b)), s8);
    chk({nm, " sat8"}, int'(sat_b), int'(t8));
    chk({nm, " count"}, int'(cnt_a), c);
  endtask

  initial begin
    vecs[0] = '{4, 0,    6,  -15,   64,   -8,   47, 0,   47, 0, 4};
    vecs[1] = '{2, 1,   12,   -3,    0,    0,    9, 0,    9, 0, 2};
    vecs[2] = '{4, 0,    1,    1,    1,    1,    4, 0,    4, 0, 4};
    vecs[3] = '{4, 0,   64,   64,  -64,  -64,    0, 0,   -1, 1, 4};
    vecs[4] = '{4, 0,  -64,  -64,  -64,    0, -192, 0, -128, 1, 4};
    vecs[5] = '{4, 0,  127,  127,  127,  127,  508, 0,  127, 1, 4};
    vecs[6] = '{4, 0, -128, -128, -128, -128, -512, 0, -128, 1, 4};
    vecs[7] = '{1, 1,   -5,    0,    0,    0,   -5, 0,   -5, 0, 1};
    vecs[8] = '{4, 1,    2,    2,    2,    2,    8, 0,    8, 0, 4};
    vecs[9] = '{3, 1, -100,  100,   -1,    0,   -1, 0,   -1, 0, 3};

    // Reset held with a product offered: nothing may be accepted.
    in_valid = 1'b1; in_prod = 8'd50;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("reset in_ready", int'(in_ready_a), 1);
      chk("reset out_valid", int'(out_valid_a), 0);
      chk("reset out_sum", int'($signed(sum_a)), 0);
      chk("reset out_count", int'(cnt_a), 0);
    end
    rst_n = 1'b1; in_valid = 1'b0;

    for (int r = 0; r < 10; r++) begin
      int pr [4];
      pr = '{vecs[r].p0, vecs[r].p1, vecs[r].p2, vecs[r].p3};
      for (int i = 0; i < vecs[r].n; i++)
        beat(pr[i], vecs[r].lst && (i == vecs[r].n - 1));
      idle();
      chk_grp($sformatf("row%0d", r), vecs[r].s10, vecs[r].t10,
              vecs[r].s8, vecs[r].t8, vecs[r].c);
      take();
    end

    // Backpressure: products offered during OUT must be ignored.
    beat(3, 0); beat(4, 0); beat(5, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_grp($sformatf("bp hold%0d", k), 12, 0, 12, 0, 3);
      in_valid = 1'b1; in_prod = 8'($urandom); in_last = 1'($urandom);
    end
    take();
    chk("bp resume in_ready", int'(in_ready_a), 1);
    beat(-7, 0); beat(2, 1); idle();
    chk_grp("bp next", -5, 0, -5, 0, 2);
    take();

    // Reset mid-group discards the partial sum.
    beat(10, 0); beat(20, 0);
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("rst mid out_valid", int'(out_valid_a), 0);
    beat(1, 0); beat(2, 0); beat(3, 0); beat(4, 0); idle();
    chk_grp("rst mid next", 10, 0, 10, 0, 4);
    take();

    // Reset while a result is pending drops it with no valid pulse.
    beat(5, 0); beat(5, 1); idle();
    chk("rst out pending", int'(out_valid_a), 1);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("rst out out_valid", int'(out_valid_a), 0);
    chk("rst out in_ready", int'(in_ready_a), 1);
    chk("rst out out_sum", int'($signed(sum_a)), 0);
    beat(7, 1); idle();
    chk_grp("rst out next", 7, 0, 7, 0, 1);
    take();

    // Random traffic against the model, biased towards extreme products.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      rst_n     = ($urandom_range(0, 199) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 5))
        0: in_prod = 8'h7F;
        1: in_prod = 8'h80;
        default: in_prod = 8'($urandom);
      endcase
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
